shift_reg_n: RTL and testbench

- Parametrised multi-stage, multi-bit enabled register chain; the next generation of the team's single-bit enabled flip-flop.
- Provides four operating modes: hold, serial shift, parallel load and rotate.
- Tracks how many stages hold valid data.
- Used as a general delay line, serial-to-parallel converter and small circular buffer in the sequential library.

---
 rtl/shift_reg_pkg.sv | 16 +
 rtl/dff_w.sv | 21 ++
 rtl/shift_reg_n.sv | 105 ++++++++++
 tb/tb_shift_reg_n.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/shift_reg_pkg.sv
// Shared types and helpers for the shift_reg_n register chain.
package shift_reg_pkg;

   typedef enum logic [1:0] {
      HOLD   = 2'd0,
      SHIFT  = 2'd1,
      LOAD   = 2'd2,
      ROTATE = 2'd3
   } mode_e;

   // Width needed to count 0..depth valid stages.
   function automatic int unsigned fill_width(input int unsigned depth);
      return $clog2(depth + 1);
   endfunction

endpackage

// File: rtl/dff_w.sv
// WIDTH-bit enabled register with synchronous active-high reset to RST_VAL.
module dff_w #(
   parameter int unsigned       WIDTH   = 8,
   parameter logic [WIDTH-1:0]  RST_VAL = '0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   always_ff @(posedge clk) begin
      if (rst) begin
         q <= RST_VAL;
      end else if (en) begin
         q <= d;
      end
   end

endmodule

// File: rtl/shift_reg_n.sv
// Multi-stage, multi-bit register chain with hold, shift, parallel load and
// rotate modes, plus a saturating count of valid stages.
module shift_reg_n
   import shift_reg_pkg::*;
#(
   parameter int unsigned       WIDTH   = 8,
   parameter int unsigned       DEPTH   = 4,
   parameter logic [WIDTH-1:0]  RST_VAL = '0
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            clr,
   input  logic                            en,
   input  mode_e                           mode,
   input  logic [WIDTH-1:0]                d,
   input  logic [DEPTH*WIDTH-1:0]          load_data,
   output logic [WIDTH-1:0]                q,
   output logic [DEPTH*WIDTH-1:0]          taps,
   output logic [fill_width(DEPTH)-1:0]    fill,
   output logic                            full
);

   localparam int unsigned FILL_W = fill_width(DEPTH);

   if (DEPTH < 1) begin : g_depth_check
      $error("shift_reg_n: DEPTH must be at least 1");
   end

   logic [DEPTH*WIDTH-1:0] stages;
   logic                   flush;
   logic [FILL_W-1:0]      fill_nxt;

   // clr behaves exactly like rst on the data path
   assign flush = rst | clr;

   for (genvar i = 0; i < DEPTH; i++) begin : g_stage
      localparam int unsigned PREV = (i == 0) ? DEPTH - 1 : i - 1;

      logic [WIDTH-1:0] cur;
      logic [WIDTH-1:0] prev_q;
      logic [WIDTH-1:0] shift_src;
      logic [WIDTH-1:0] nxt;

      assign cur       = stages[i*WIDTH +: WIDTH];
      assign prev_q    = stages[PREV*WIDTH +: WIDTH];
      assign shift_src = (i == 0) ? d : prev_q;

      always_comb begin
         nxt = cur;
         case (mode)
            SHIFT:   nxt = shift_src;
            LOAD:    nxt = load_data[i*WIDTH +: WIDTH];
            ROTATE:  nxt = prev_q;
            default: nxt = cur;
         endcase
      end

      dff_w #(
         .WIDTH   (WIDTH),
         .RST_VAL (RST_VAL)
      ) u_ff (
         .clk (clk),
         .rst (flush),
         .en  (en),
         .d   (nxt),
         .q   (stages[i*WIDTH +: WIDTH])
      );
   end

   assign taps = stages;
   assign q    = stages[(DEPTH-1)*WIDTH +: WIDTH];

   // Valid-stage count: saturates on shift, jumps to DEPTH on load, rotate keeps it
   always_comb begin
      fill_nxt = fill;
      if (clr) begin
         fill_nxt = '0;
      end else if (en) begin
         case (mode)
            SHIFT: begin
               if (fill != FILL_W'(DEPTH)) begin
                  fill_nxt = fill + FILL_W'(1);
               end
            end
            LOAD:    fill_nxt = FILL_W'(DEPTH);
            default: fill_nxt = fill;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         fill <= '0;
         full <= 1'b0;
      end else begin
         fill <= fill_nxt;
         full <= (fill_nxt == FILL_W'(DEPTH));
      end
   end

   mode_known_a : assert property (@(posedge clk) disable iff (rst)
                                   en |-> !$isunknown(mode))
      else $error("shift_reg_n: mode is unknown while enabled");

endmodule

// File: tb/tb_shift_reg_n.sv
// Directed bench for shift_reg_n: DEPTH=4 main instance plus a DEPTH=1 instance.
module tb_shift_reg_n;
   import shift_reg_pkg::*;

   logic        clk;
   logic        rst;
   logic        clr;
   logic        en;
   mode_e       mode;
   logic [7:0]  d;
   logic [31:0] load_data;
   logic [7:0]  q;
   logic [31:0] taps;
   logic [2:0]  fill;
   logic        full;

   logic [7:0]  load_data1;
   logic [7:0]  q1;
   logic [7:0]  taps1;
   logic [0:0]  fill1;
   logic        full1;

   int checks;
   int errors;

   shift_reg_n #(.WIDTH(8), .DEPTH(4), .RST_VAL(8'h00)) dut (
      .clk       (clk),
      .rst       (rst),
      .clr       (clr),
      .en        (en),
      .mode      (mode),
      .d         (d),
      .load_data (load_data),
      .q         (q),
      .taps      (taps),
      .fill      (fill),
      .full      (full)
   );

   shift_reg_n #(.WIDTH(8), .DEPTH(1), .RST_VAL(8'h00)) dut1 (
      .clk       (clk),
      .rst       (rst),
      .clr       (clr),
      .en        (en),
      .mode      (mode),
      .d         (d),
      .load_data (load_data1),
      .q         (q1),
      .taps      (taps1),
      .fill      (fill1),
      .full      (full1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; en = 1'b1; mode = SHIFT; d = 8'hFF;
      step();
      rst = 1'b0;
      checks++; if (taps !== 32'h0) begin errors++; $display("FAIL reset_taps got %h exp %h", taps, 32'h0); end
      checks++; if (q !== 8'h00) begin errors++; $display("FAIL reset_q got %h exp %h", q, 8'h00); end
      checks++; if (fill !== 3'd0) begin errors++; $display("FAIL reset_fill got %0d exp 0", fill); end
      checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full got %b exp 0", full); end
   endtask

   task automatic test_shift_enable();
      logic [7:0]  vals [5];
      logic [31:0] exp_taps [5];
      logic [2:0]  exp_fill [5];
      vals     = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
      exp_taps = '{32'h00000011, 32'h00001122, 32'h00112233, 32'h11223344, 32'h22334455};
      exp_fill = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd4};
      en = 1'b0; mode = SHIFT;
      for (int k = 0; k < 4; k++) begin
         d = (k % 2 == 0) ? 8'hA5 : 8'h5A;
         step();
         checks++; if (taps !== 32'h0) begin errors++; $display("FAIL en0_taps[%0d] got %h exp %h", k, taps, 32'h0); end
         checks++; if (fill !== 3'd0) begin errors++; $display("FAIL en0_fill[%0d] got %0d exp 0", k, fill); end
      end
      en = 1'b1;
      for (int k = 0; k < 5; k++) begin
         d = vals[k];
         step();
         checks++; if (taps !== exp_taps[k]) begin errors++; $display("FAIL shift_taps[%0d] got %h exp %h", k, taps, exp_taps[k]); end
         checks++; if (fill !== exp_fill[k]) begin errors++; $display("FAIL shift_fill[%0d] got %0d exp %0d", k, fill, exp_fill[k]); end
         checks++; if (full !== (k >= 3)) begin errors++; $display("FAIL shift_full[%0d] got %b exp %b", k, full, (k >= 3)); end
      end
      checks++; if (q !== 8'h22) begin errors++; $display("FAIL shift_sat_q got %h exp %h", q, 8'h22); end
   endtask

   task automatic test_load_rotate();
      logic [7:0] exp_q [4];
      exp_q = '{8'hC2, 8'hB1, 8'hA0, 8'hD3};
      en = 1'b1; mode = LOAD; load_data = 32'hD3C2B1A0;
      step();
      checks++; if (fill !== 3'd4) begin errors++; $display("FAIL load_fill got %0d exp 4", fill); end
      checks++; if (q !== 8'hD3) begin errors++; $display("FAIL load_q got %h exp %h", q, 8'hD3); end
      checks++; if (taps !== 32'hD3C2B1A0) begin errors++; $display("FAIL load_taps got %h exp %h", taps, 32'hD3C2B1A0); end
      mode = ROTATE; load_data = 32'h0;
      for (int k = 0; k < 4; k++) begin
         step();
         checks++; if (q !== exp_q[k]) begin errors++; $display("FAIL rot_q[%0d] got %h exp %h", k, q, exp_q[k]); end
         checks++; if (fill !== 3'd4) begin errors++; $display("FAIL rot_fill[%0d] got %0d exp 4", k, fill); end
      end
      checks++; if (taps !== 32'hD3C2B1A0) begin errors++; $display("FAIL rot_taps got %h exp %h", taps, 32'hD3C2B1A0); end
   endtask

   task automatic test_clear();
      clr = 1'b1; en = 1'b0;
      step();
      clr = 1'b0;
      checks++; if (fill !== 3'd0) begin errors++; $display("FAIL clr_idle_fill got %0d exp 0", fill); end
      en = 1'b1; mode = SHIFT;
      d = 8'h77; step();
      d = 8'h88; step();
      checks++; if (taps !== 32'h00007788) begin errors++; $display("FAIL clr_pre_taps got %h exp %h", taps, 32'h00007788); end
      checks++; if (fill !== 3'd2) begin errors++; $display("FAIL clr_pre_fill got %0d exp 2", fill); end
      clr = 1'b1; mode = LOAD; load_data = 32'hFFFFFFFF;
      step();
      checks++; if (taps !== 32'h0) begin errors++; $display("FAIL clr_load_taps got %h exp %h", taps, 32'h0); end
      checks++; if (fill !== 3'd0) begin errors++; $display("FAIL clr_load_fill got %0d exp 0", fill); end
      checks++; if (full !== 1'b0) begin errors++; $display("FAIL clr_load_full got %b exp 0", full); end
      rst = 1'b1; mode = SHIFT; d = 8'h99;
      step();
      rst = 1'b0; clr = 1'b0;
      checks++; if (taps !== 32'h0) begin errors++; $display("FAIL rstclr_taps got %h exp %h", taps, 32'h0); end
      checks++; if (fill !== 3'd0) begin errors++; $display("FAIL rstclr_fill got %0d exp 0", fill); end
   endtask

   task automatic test_hold();
      en = 1'b1; mode = LOAD; load_data = 32'hD3C2B1A0;
      step();
      load_data = 32'h12345678;
      for (int k = 0; k < 6; k++) begin
         if (k < 3) begin en = 1'b1; mode = HOLD; end
         else       begin en = 1'b0; mode = ROTATE; end
         d = 8'hEE;
         step();
         checks++; if (taps !== 32'hD3C2B1A0) begin errors++; $display("FAIL hold_taps[%0d] got %h exp %h", k, taps, 32'hD3C2B1A0); end
         checks++; if (q !== 8'hD3) begin errors++; $display("FAIL hold_q[%0d] got %h exp %h", k, q, 8'hD3); end
         checks++; if (fill !== 3'd4) begin errors++; $display("FAIL hold_fill[%0d] got %0d exp 4", k, fill); end
         checks++; if (full !== 1'b1) begin errors++; $display("FAIL hold_full[%0d] got %b exp 1", k, full); end
      end
   endtask

   task automatic test_depth1();
      rst = 1'b1; en = 1'b0;
      step();
      rst = 1'b0;
      checks++; if (fill1 !== 1'b0) begin errors++; $display("FAIL d1_reset_fill got %0d exp 0", fill1); end
      en = 1'b1; mode = SHIFT; d = 8'h5A;
      step();
      checks++; if (q1 !== 8'h5A) begin errors++; $display("FAIL d1_shift_q got %h exp %h", q1, 8'h5A); end
      checks++; if (full1 !== 1'b1) begin errors++; $display("FAIL d1_shift_full got %b exp 1", full1); end
      checks++; if (taps1 !== 8'h5A) begin errors++; $display("FAIL d1_shift_taps got %h exp %h", taps1, 8'h5A); end
      mode = ROTATE; d = 8'h00;
      step();
      checks++; if (q1 !== 8'h5A) begin errors++; $display("FAIL d1_rot_q got %h exp %h", q1, 8'h5A); end
      checks++; if (fill1 !== 1'b1) begin errors++; $display("FAIL d1_rot_fill got %0d exp 1", fill1); end
      mode = SHIFT; d = 8'hC3;
      step();
      checks++; if (q1 !== 8'hC3) begin errors++; $display("FAIL d1_shift2_q got %h exp %h", q1, 8'hC3); end
      checks++; if (full1 !== 1'b1) begin errors++; $display("FAIL d1_shift2_full got %b exp 1", full1); end
   endtask

   initial begin
      checks = 0; errors = 0;
      rst = 1'b1; clr = 1'b0; en = 1'b0; mode = HOLD; d = 8'h00;
      load_data = 32'h0; load_data1 = 8'h00;
      test_reset();
      test_shift_enable();
      test_load_rotate();
      test_clear();
      test_hold();
      test_depth1();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
